pipeline_fwd_scoreboard: RTL and testbench
==========================================

# pipeline_fwd_scoreboard

Parametrised issue-side hazard unit for the RV32 pipeline. It tracks the destination registers of the last FWD_DEPTH issued instructions, generates per-source forwarding selects and load-use stalls for a configurable load latency, and supports flush. It sits between decode and execute and generalises the fixed two-deep rs1/rs2 forwarding logic of the decode stage to any depth. It also adds flush and a stall-cycle counter.

## Interface
- FWD_DEPTH, 2: number of older in-flight producers tracked, legal 1..4.
- LOAD_LAT, 1: load-to-use penalty in slots; a load at distance k ≤ LOAD_LAT cannot be forwarded. Legal 0..FWD_DEPTH-1.
- SEL_W, $clog2(FWD_DEPTH+1): width of the forwarding selects.
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- dec_valid_i  in  1  a decoded instruction is presented.
- rs1_i, rs2_i  in  5  source register indices.
- rs1_used_i, rs2_used_i  in  1  the source is actually read.
- rd_i  in  5  destination register index.
- rd_wr_i  in  1  the instruction writes rd.
- is_load_i  in  1  the instruction is a load.
- flush_i  in  1  kill all tracked producers (redirect).
- valid_stall_i  in  1  downstream hold; freezes all state.
- issue_o  out  1  the instruction is accepted this cycle (combinational).
- stall_load_o  out  1  load-use hazard; decode must hold (combinational).
- out_valid_o  out  1  registered; the issued instruction occupies the next stage.
- fwd_rs1_o, fwd_rs2_o  out  SEL_W  registered; 0 = register file, k = forward from the producer k issue slots older.
- stall_cnt_o  out  16  saturating count of load-use stall cycles.

## Operation
- History is a shift register of FWD_DEPTH entries {valid, rd, load}. Entry 1 is the youngest.
- Match of source s against entry k: valid_k & rd_k == s & s != 0 & s_used.
- sel_s = smallest matching k, or 0 if there is no match. The youngest producer always wins.
- stall_load_o = dec_valid_i & ~flush_i & (for rs1 or rs2: sel_s != 0 & load at sel_s & sel_s ≤ LOAD_LAT).
  - Both sources hitting the same load give a single stall.
  - When LOAD_LAT = 0, stall_load_o is constant 0.
- issue_o = dec_valid_i & ~stall_load_o & ~valid_stall_i & ~flush_i.
- The incoming entry is {rd_wr_i & rd_i != 0, rd_i, is_load_i}.
  - Entries with rd = x0 or no write are stored invalid.
- Per edge, in priority order:
  - reset_i: all history invalid; out_valid_o = 0; fwd selects = 0; stall_cnt_o = 0.
  - flush_i: all history invalid; out_valid_o = 0; fwd selects = 0. stall_cnt_o holds.
  - valid_stall_i: all state and outputs hold.
  - issue_o: history shifts and the new entry enters at slot 1; out_valid_o = 1; fwd_rsX_o = sel_X.
  - Otherwise (bubble, or stall_load_o): history shifts with an invalid entry at slot 1; out_valid_o = 0; fwd selects = 0.
- stall_cnt_o increments on each edge where stall_load_o & ~valid_stall_i & ~reset_i is true. It saturates at 16'hFFFF.
- Entries older than FWD_DEPTH are dropped; their results come from the register file.

## Timing
- Hazard detection is zero-cycle: stall_load_o and issue_o are valid in the same cycle as the decode inputs.
- fwd_rs*_o and out_valid_o appear one cycle after issue, aligned with the execute stage.
- A load followed immediately by a consumer, with LOAD_LAT = 1:
  - One stall cycle. The load then sits at slot 2 and the consumer issues with select 2.
- A stall lasts exactly LOAD_LAT + 1 − k cycles for a load at distance k. Decode holds its inputs throughout.
- While valid_stall_i is high, stall_load_o still evaluates but nothing advances. The counter does not count held cycles.
- flush_i in the same cycle as an issue candidate: the instruction is not issued; the flush wins.
- reset_i mid-sequence clears history; the next consumer sees select 0.

## Test plan
- Defaults (FWD_DEPTH = 2, LOAD_LAT = 1). Issue add x5 then add x6,x5,x0 back-to-back.
  - On the cycle after the second issue: fwd_rs1_o = 1, fwd_rs2_o = 0, out_valid_o = 1.
- Issue add x5, add x9,x1,x2, then sub x3,x5,x5.
  - Third instruction: fwd_rs1_o = 2, fwd_rs2_o = 2.
- Issue lw x7 then add x8,x7,x7.
  - stall_load_o = 1 for exactly one cycle; stall_cnt_o = 1.
  - The add then issues with fwd_rs1_o = fwd_rs2_o = 2. The intervening bubble shows out_valid_o = 0.
- Corner cases on forwarding selection:
  - Producer with rd = x0, then consumer rs1 = x0: select 0.
  - Consumer matching rs2 with rs2_used_i = 0: fwd_rs2_o = 0.
  - add x5 twice back-to-back, then consumer of x5: select 1.
- Hold, flush and reset:
  - Hold valid_stall_i for 3 cycles between producer x5 and consumer x5: all outputs frozen, and the consumer later gets select 1.
  - Assert flush_i between them: the consumer gets select 0.
  - Assert reset_i mid-stall: stall_cnt_o = 0 and stall_load_o = 0 on the next cycle.
- FWD_DEPTH = 4, LOAD_LAT = 2. Issue lw x4, nop, then a consumer of x4.
  - One stall cycle, then the consumer issues with select 3.
  - A producer at distance 5 gives select 0.

Source files
------------

// File: rtl/pipeline_fwd_scoreboard_if.sv
// Decode-to-hazard-unit bundle: decoded instruction fields in, issue/stall/forwarding results out.
interface pipeline_fwd_scoreboard_if #(
  parameter int unsigned SEL_W = 2
);
  logic             dec_valid_i;
  logic [4:0]       rs1_i;
  logic [4:0]       rs2_i;
  logic             rs1_used_i;
  logic             rs2_used_i;
  logic [4:0]       rd_i;
  logic             rd_wr_i;
  logic             is_load_i;
  logic             flush_i;
  logic             valid_stall_i;
  logic             issue_o;
  logic             stall_load_o;
  logic             out_valid_o;
  logic [SEL_W-1:0] fwd_rs1_o;
  logic [SEL_W-1:0] fwd_rs2_o;
  logic [15:0]      stall_cnt_o;

  modport master (
    output dec_valid_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i, rd_i, rd_wr_i, is_load_i,
    output flush_i, valid_stall_i,
    input  issue_o, stall_load_o, out_valid_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
  );

  modport slave (
    input  dec_valid_i, rs1_i, rs2_i, rs1_used_i, rs2_used_i, rd_i, rd_wr_i, is_load_i,
    input  flush_i, valid_stall_i,
    output issue_o, stall_load_o, out_valid_o, fwd_rs1_o, fwd_rs2_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_fwd_scoreboard.sv
// Issue-side hazard unit: tracks the last FWD_DEPTH destinations, picks forwarding sources
// and raises load-use stalls; index 0 of the history is the youngest producer (slot 1).
module pipeline_fwd_scoreboard #(
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input logic                      clk_i,
  input logic                      reset_i,
  pipeline_fwd_scoreboard_if.slave bus
);

  logic [FWD_DEPTH-1:0]      hv_q, hv_d;
  logic [FWD_DEPTH-1:0]      hld_q, hld_d;
  logic [FWD_DEPTH-1:0][4:0] hrd_q, hrd_d;
  logic                      ov_q, ov_d;
  logic [SEL_W-1:0]          f1_q, f1_d, f2_q, f2_d;
  logic [15:0]               cnt_q, cnt_d;

  logic [SEL_W-1:0] sel1, sel2;
  logic             near1, near2;
  logic             stall_load, issue;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel1  = '0;
    sel2  = '0;
    near1 = 1'b0;
    near2 = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (hv_q[k] && hrd_q[k] == bus.rs1_i && bus.rs1_i != 5'd0 && bus.rs1_used_i) begin
        sel1  = SEL_W'(k + 1);
        near1 = hld_q[k] && (k + 1 <= int'(LOAD_LAT));
      end
      if (hv_q[k] && hrd_q[k] == bus.rs2_i && bus.rs2_i != 5'd0 && bus.rs2_used_i) begin
        sel2  = SEL_W'(k + 1);
        near2 = hld_q[k] && (k + 1 <= int'(LOAD_LAT));
      end
    end
  end

  assign stall_load = bus.dec_valid_i & ~bus.flush_i & (near1 | near2);
  assign issue      = bus.dec_valid_i & ~stall_load & ~bus.valid_stall_i & ~bus.flush_i;

  always_comb begin
    hv_d  = hv_q;
    hld_d = hld_q;
    hrd_d = hrd_q;
    ov_d  = ov_q;
    f1_d  = f1_q;
    f2_d  = f2_q;
    if (bus.flush_i) begin
      hv_d = '0;
      ov_d = 1'b0;
      f1_d = '0;
      f2_d = '0;
    end else if (!bus.valid_stall_i) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        hv_d[k]  = hv_q[k-1];
        hld_d[k] = hld_q[k-1];
        hrd_d[k] = hrd_q[k-1];
      end
      // Bubbles and stalled slots enter as invalid entries so older producers still age.
      hv_d[0]  = issue & bus.rd_wr_i & (bus.rd_i != 5'd0);
      hld_d[0] = bus.is_load_i;
      hrd_d[0] = bus.rd_i;
      ov_d     = issue;
      f1_d     = issue ? sel1 : '0;
      f2_d     = issue ? sel2 : '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_load && !bus.valid_stall_i && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hv_q  <= '0;
      hld_q <= '0;
      hrd_q <= '0;
      ov_q  <= 1'b0;
      f1_q  <= '0;
      f2_q  <= '0;
      cnt_q <= '0;
    end else begin
      hv_q  <= hv_d;
      hld_q <= hld_d;
      hrd_q <= hrd_d;
      ov_q  <= ov_d;
      f1_q  <= f1_d;
      f2_q  <= f2_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.issue_o      = issue;
  assign bus.stall_load_o = stall_load;
  assign bus.out_valid_o  = ov_q;
  assign bus.fwd_rs1_o    = f1_q;
  assign bus.fwd_rs2_o    = f2_q;
  assign bus.stall_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pipeline_fwd_scoreboard.sv
// Bench for the hazard unit: DUT A uses the defaults, DUT B uses depth 4 / load latency 2.
module tb_pipeline_fwd_scoreboard;

  localparam int X = -1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  bit         sel_dut = 1'b0;
  logic       dv = 1'b0, u1 = 1'b0, u2 = 1'b0, wr = 1'b0, ld = 1'b0;
  logic       flush = 1'b0, vs = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] lasta = '0, lastb = '0;
  bit         vsa_q = 1'b0, vsb_q = 1'b0;

  always #5 clk = ~clk;

  pipeline_fwd_scoreboard_if #(.SEL_W(2)) ia ();
  pipeline_fwd_scoreboard_if #(.SEL_W(3)) ib ();

  assign ia.dec_valid_i   = dv & ~sel_dut;
  assign ia.flush_i       = flush & ~sel_dut;
  assign ia.valid_stall_i = vs & ~sel_dut;
  assign ia.rs1_i = rs1;  assign ia.rs2_i = rs2;  assign ia.rd_i = rd;
  assign ia.rs1_used_i = u1;  assign ia.rs2_used_i = u2;
  assign ia.rd_wr_i = wr;  assign ia.is_load_i = ld;

  assign ib.dec_valid_i   = dv & sel_dut;
  assign ib.flush_i       = flush & sel_dut;
  assign ib.valid_stall_i = vs & sel_dut;
  assign ib.rs1_i = rs1;  assign ib.rs2_i = rs2;  assign ib.rd_i = rd;
  assign ib.rs1_used_i = u1;  assign ib.rs2_used_i = u2;
  assign ib.rd_wr_i = wr;  assign ib.is_load_i = ld;

  pipeline_fwd_scoreboard #(.FWD_DEPTH(2), .LOAD_LAT(1)) dut_a (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (ia)
  );

  pipeline_fwd_scoreboard #(.FWD_DEPTH(4), .LOAD_LAT(2)) dut_b (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (ib)
  );

  logic        s_issue, s_stall, s_ov;
  logic [15:0] s_cnt;
  assign s_issue = sel_dut ? ib.issue_o      : ia.issue_o;
  assign s_stall = sel_dut ? ib.stall_load_o : ia.stall_load_o;
  assign s_ov    = sel_dut ? ib.out_valid_o  : ia.out_valid_o;
  assign s_cnt   = sel_dut ? ib.stall_cnt_o  : ia.stall_cnt_o;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Monitors: a fresh output pops the scoreboard; an output held by valid_stall must not move.
  always @(posedge clk) begin
    vsa_q <= ia.valid_stall_i;
    vsb_q <= ib.valid_stall_i;
  end

  always @(negedge clk) begin
    if (ia.out_valid_o) begin
      if (vsa_q) begin
        chk("A held fwd_rs1", int'(ia.fwd_rs1_o), int'(lasta[7:4]));
        chk("A held fwd_rs2", int'(ia.fwd_rs2_o), int'(lasta[3:0]));
      end else if (qa.size() == 0) begin
        chk("A unexpected out_valid (queue size)", qa.size(), 1);
      end else begin
        lasta = qa.pop_front();
        chk("A fwd_rs1", int'(ia.fwd_rs1_o), int'(lasta[7:4]));
        chk("A fwd_rs2", int'(ia.fwd_rs2_o), int'(lasta[3:0]));
      end
    end
    if (ib.out_valid_o) begin
      if (vsb_q) begin
        chk("B held fwd_rs1", int'(ib.fwd_rs1_o), int'(lastb[7:4]));
        chk("B held fwd_rs2", int'(ib.fwd_rs2_o), int'(lastb[3:0]));
      end else if (qb.size() == 0) begin
        chk("B unexpected out_valid (queue size)", qb.size(), 1);
      end else begin
        lastb = qb.pop_front();
        chk("B fwd_rs1", int'(ib.fwd_rs1_o), int'(lastb[7:4]));
        chk("B fwd_rs2", int'(ib.fwd_rs2_o), int'(lastb[3:0]));
      end
    end
  end

  task automatic ins(input logic [4:0] a, input logic ua, input logic [4:0] b, input logic ub,
                     input logic [4:0] d, input logic w, input logic l);
    dv = 1'b1;  rs1 = a;  u1 = ua;  rs2 = b;  u2 = ub;  rd = d;  wr = w;  ld = l;
  endtask

  task automatic idle();
    dv = 1'b0;
  endtask

  // One cycle: check combinational outputs and last cycle's registered ones, then clock.
  task automatic step(input string nm, input int e_iss, input int e_stl, input int e_ov,
                      input int es1, input int es2, input int e_cnt);
    @(negedge clk);
    if (e_iss >= 0) chk({nm, " issue_o"}, int'(s_issue), e_iss);
    if (e_stl >= 0) chk({nm, " stall_load_o"}, int'(s_stall), e_stl);
    if (e_ov >= 0)  chk({nm, " out_valid_o"}, int'(s_ov), e_ov);
    if (e_cnt >= 0) chk({nm, " stall_cnt_o"}, int'(s_cnt), e_cnt);
    if (e_iss == 1) begin
      if (sel_dut) qb.push_back({4'(es1), 4'(es2)});
      else         qa.push_back({4'(es1), 4'(es2)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset A out_valid", int'(ia.out_valid_o), 0);
    chk("reset A fwd_rs1", int'(ia.fwd_rs1_o), 0);
    chk("reset A fwd_rs2", int'(ia.fwd_rs2_o), 0);
    chk("reset A stall_cnt", int'(ia.stall_cnt_o), 0);
    chk("reset B out_valid", int'(ib.out_valid_o), 0);
    chk("reset B stall_cnt", int'(ib.stall_cnt_o), 0);

    sel_dut = 1'b0;
    ins(1, 1, 2, 1, 5, 1, 0);  step("t1 add x5", 1, 0, 0, 0, 0, X);
    ins(5, 1, 0, 1, 6, 1, 0);  step("t1 dist1", 1, 0, 1, 1, 0, X);
    idle();                    step("t1 idle", 0, 0, 1, 0, 0, X);

    ins(1, 1, 2, 1, 5, 1, 0);  step("t2 add x5", 1, 0, 0, 0, 0, X);
    ins(1, 1, 2, 1, 9, 1, 0);  step("t2 add x9", 1, 0, 1, 0, 0, X);
    ins(5, 1, 5, 1, 3, 1, 0);  step("t2 dist2", 1, 0, 1, 2, 2, X);
    idle();                    step("t2 idle", 0, 0, 1, 0, 0, X);

    ins(1, 1, 0, 0, 7, 1, 1);  step("t3 lw x7", 1, 0, 0, 0, 0, 0);
    ins(7, 1, 7, 1, 8, 1, 0);  step("t3 load-use", 0, 1, 1, 0, 0, 0);
                               step("t3 use", 1, 0, 0, 2, 2, 1);
    idle();                    step("t3 idle", 0, 0, 1, 0, 0, 1);

    ins(1, 1, 2, 1, 0, 1, 0);  step("t4 rd x0", 1, 0, 0, 0, 0, X);
    ins(0, 1, 2, 1, 10, 1, 0); step("t4 rs1 x0", 1, 0, 1, 0, 0, X);
    ins(1, 1, 10, 0, 11, 1, 0); step("t4 rs2 unused", 1, 0, 1, 0, 0, X);
    ins(1, 1, 2, 1, 5, 1, 0);  step("t4 x5 first", 1, 0, 1, 0, 0, X);
                               step("t4 x5 second", 1, 0, 1, 0, 0, X);
    ins(5, 1, 2, 1, 12, 1, 0); step("t4 youngest", 1, 0, 1, 1, 0, X);
    idle();                    step("t4 idle", 0, 0, 1, 0, 0, X);

    ins(1, 1, 2, 1, 5, 1, 0);  step("t5 add x5", 1, 0, 0, 0, 0, X);
    ins(5, 1, 5, 1, 13, 1, 0);
    vs = 1'b1;
    repeat (3) step("t5 hold", 0, 0, 1, 0, 0, 1);
    vs = 1'b0;                 step("t5 use", 1, 0, 1, 1, 1, 1);
    idle();                    step("t5 idle", 0, 0, 1, 0, 0, X);

    ins(1, 1, 2, 1, 5, 1, 0);  step("t6 add x5", 1, 0, 0, 0, 0, X);
    ins(5, 1, 5, 1, 14, 1, 0);
    flush = 1'b1;              step("t6 flush", 0, 0, 1, 0, 0, X);
    flush = 1'b0;              step("t6 use", 1, 0, 0, 0, 0, X);
    idle();                    step("t6 idle", 0, 0, 1, 0, 0, X);

    ins(1, 1, 0, 0, 7, 1, 1);  step("t7 lw x7", 1, 0, 0, 0, 0, X);
    ins(7, 1, 0, 0, 8, 1, 0);
    reset = 1'b1;              step("t7 stall+reset", 0, 1, 1, 0, 0, 1);
    reset = 1'b0;              step("t7 after reset", 1, 0, 0, 0, 0, 0);
    idle();                    step("t7 idle", 0, 0, 1, 0, 0, 0);

    sel_dut = 1'b1;
    ins(1, 1, 0, 0, 4, 1, 1);  step("t8 lw x4", 1, 0, 0, 0, 0, 0);
    idle();                    step("t8 nop", 0, 0, 1, 0, 0, 0);
    ins(4, 1, 2, 1, 9, 1, 0);  step("t8 load-use", 0, 1, 0, 0, 0, 0);
                               step("t8 use", 1, 0, 0, 3, 0, 1);
    ins(1, 1, 2, 1, 20, 1, 0); step("t9 add x20", 1, 0, 1, 0, 0, 1);
    for (int r = 21; r <= 24; r++) begin
      ins(1, 1, 2, 1, 5'(r), 1, 0);
      step("t9 filler", 1, 0, 1, 0, 0, X);
    end
    ins(20, 1, 21, 1, 25, 1, 0); step("t9 dist5/dist4", 1, 0, 1, 0, 4, X);
    idle();                    step("t9 idle", 0, 0, 1, 0, 0, X);
    idle();                    step("t9 drain", 0, 0, 0, 0, 0, X);

    chk("A scoreboard drained", qa.size(), 0);
    chk("B scoreboard drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
